mul_64: RTL and testbench



---
 rtl/mul_pkg.sv | 13 +
 rtl/mul_64_if.sv | 27 ++
 rtl/mul_32x32.sv | 12 +
 rtl/mul_64.sv | 72 +++++++
 tb/tb_mul_64.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared widths and types for the 64x64 pipelined multiplier
package mul_pkg;

  localparam int WIDTH   = 64;
  localparam int HALF    = 32;
  localparam int LATENCY = 3;

  typedef logic [WIDTH-1:0]   operand_t;
  typedef logic [HALF-1:0]    half_t;
  typedef logic [2*HALF-1:0]  pprod_t;
  typedef logic [2*WIDTH-1:0] product_t;

endpackage

// File: rtl/mul_64_if.sv
// rtl/mul_64_if.sv - operand/result bundle for mul_64
interface mul_64_if;
  import mul_pkg::*;

  logic     in_valid;
  operand_t a;
  operand_t b;
  logic     out_valid;
  product_t result;

  modport master (
    output in_valid,
    output a,
    output b,
    input  out_valid,
    input  result
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    output out_valid,
    output result
  );

endinterface

// File: rtl/mul_32x32.sv
// rtl/mul_32x32.sv - combinational unsigned 32x32 -> 64 multiply
module mul_32x32
  import mul_pkg::*;
(
  input  half_t  a_i,
  input  half_t  b_i,
  output pprod_t p_o
);

  assign p_o = pprod_t'(a_i) * pprod_t'(b_i);

endmodule

// File: rtl/mul_64.sv
// rtl/mul_64.sv - 3-stage unsigned 64x64 -> 128 multiplier, one product per clock
module mul_64
  import mul_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  mul_64_if.slave  bus
);

  operand_t a_q, b_q;
  logic     v1_q;

  pprod_t   pp_ll_d, pp_lh_d, pp_hl_d, pp_hh_d;
  pprod_t   pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
  logic     v2_q;

  product_t result_d, result_q;
  logic     v3_q;

  half_t    a_hi, a_lo, b_hi, b_lo;

  assign a_hi = a_q[WIDTH-1:HALF];
  assign a_lo = a_q[HALF-1:0];
  assign b_hi = b_q[WIDTH-1:HALF];
  assign b_lo = b_q[HALF-1:0];

  mul_32x32 u_mul_ll (.a_i(a_lo), .b_i(b_lo), .p_o(pp_ll_d));
  mul_32x32 u_mul_lh (.a_i(a_lo), .b_i(b_hi), .p_o(pp_lh_d));
  mul_32x32 u_mul_hl (.a_i(a_hi), .b_i(b_lo), .p_o(pp_hl_d));
  mul_32x32 u_mul_hh (.a_i(a_hi), .b_i(b_hi), .p_o(pp_hh_d));

  // Result only updates on a valid S2 entry so it holds the last product otherwise.
  always_comb begin
    result_d = result_q;
    if (v2_q) begin
      result_d = product_t'(pp_ll_q)
               + (product_t'(pp_lh_q) << HALF)
               + (product_t'(pp_hl_q) << HALF)
               + (product_t'(pp_hh_q) << WIDTH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      v1_q     <= 1'b0;
      pp_ll_q  <= '0;
      pp_lh_q  <= '0;
      pp_hl_q  <= '0;
      pp_hh_q  <= '0;
      v2_q     <= 1'b0;
      result_q <= '0;
      v3_q     <= 1'b0;
    end else begin
      a_q      <= bus.a;
      b_q      <= bus.b;
      v1_q     <= bus.in_valid;
      pp_ll_q  <= pp_ll_d;
      pp_lh_q  <= pp_lh_d;
      pp_hl_q  <= pp_hl_d;
      pp_hh_q  <= pp_hh_d;
      v2_q     <= v1_q;
      result_q <= result_d;
      v3_q     <= v2_q;
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_mul_64.sv
// tb/tb_mul_64.sv - directed and random self-checking bench for mul_64
module tb_mul_64;

  logic clk;
  logic rst;

  mul_64_if bus();

  mul_64 u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference pipeline: entry [2] is what the DUT should present after the current edge.
  logic         m_v[3];
  logic [127:0] m_p[3];
  logic [127:0] m_res;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_v[i] = 1'b0;
      m_p[i] = '0;
    end
    m_res = '0;
  endtask

  task automatic step(input logic v, input logic [63:0] x, input logic [63:0] y);
    bus.in_valid = v;
    bus.a        = x;
    bus.b        = y;
    @(posedge clk);
    m_v[2] = m_v[1];
    m_p[2] = m_p[1];
    m_v[1] = m_v[0];
    m_p[1] = m_p[0];
    m_v[0] = v;
    m_p[0] = {64'h0, x} * {64'h0, y};
    if (m_v[2]) m_res = m_p[2];
    #1;
    check("model_out_valid", {127'h0, bus.out_valid}, {127'h0, m_v[2]});
    check("model_result", bus.result, m_res);
  endtask

  task automatic run_one(input string tag, input logic [63:0] x, input logic [63:0] y,
                         input logic [127:0] exp);
    step(1'b1, x, y);
    step(1'b0, 64'h0, 64'h0);
    step(1'b0, 64'h0, 64'h0);
    check({tag, "_ov"}, {127'h0, bus.out_valid}, 128'h1);
    check({tag, "_res"}, bus.result, exp);
    step(1'b0, 64'hDEAD_BEEF_0000_0001, 64'h0F0F_0F0F_0F0F_0F0F);
    check({tag, "_ov_drop"}, {127'h0, bus.out_valid}, 128'h0);
    check({tag, "_hold"}, bus.result, exp);
  endtask

  logic [63:0]  sa[5];
  logic [63:0]  sb[5];
  logic [127:0] se[5];

  initial begin
    model_clear();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    @(posedge clk);
    #1;
    check("reset_ov", {127'h0, bus.out_valid}, 128'h0);
    check("reset_res", bus.result, 128'h0);
    rst = 1'b0;

    run_one("alt", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
            128'h38E38E38E38E38E3_1C71C71C71C71C72);
    run_one("max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            128'hFFFFFFFFFFFFFFFE_0000000000000001);
    run_one("zero", 64'h0, 64'h1234_5678_9ABC_DEF0, 128'h0);
    run_one("ident", 64'h1, 64'h1234_5678_9ABC_DEF0,
            128'h0000000000000000_123456789ABCDEF0);

    // Back-to-back stream
    sa[0] = 64'd2;                   sb[0] = 64'd3;                   se[0] = 128'd6;
    sa[1] = 64'h0000_0001_0000_0000; sb[1] = 64'h0000_0001_0000_0000; se[1] = 128'h1_0000_0000_0000_0000;
    sa[2] = 64'h8000_0000_0000_0000; sb[2] = 64'd2;                   se[2] = 128'h1_0000_0000_0000_0000;
    sa[3] = 64'd7;                   sb[3] = 64'd9;                   se[3] = 128'd63;
    sa[4] = {$urandom, $urandom};    sb[4] = {$urandom, $urandom};
    se[4] = {64'h0, sa[4]} * {64'h0, sb[4]};
    for (int i = 0; i < 7; i++) begin
      if (i < 5) step(1'b1, sa[i], sb[i]);
      else       step(1'b0, 64'h0, 64'h0);
      if (i >= 2) begin
        check("stream_ov", {127'h0, bus.out_valid}, 128'h1);
        check("stream_res", bus.result, se[i-2]);
      end
    end

    // Gap in in_valid reappears as a gap in out_valid
    step(1'b1, 64'd11, 64'd13);
    step(1'b0, 64'd5, 64'd5);
    step(1'b1, 64'd17, 64'd19);
    check("gap_ov0", {127'h0, bus.out_valid}, 128'h1);
    check("gap_res0", bus.result, 128'd143);
    step(1'b0, 64'h0, 64'h0);
    check("gap_ov1", {127'h0, bus.out_valid}, 128'h0);
    check("gap_hold", bus.result, 128'd143);
    step(1'b0, 64'h0, 64'h0);
    check("gap_ov2", {127'h0, bus.out_valid}, 128'h1);
    check("gap_res2", bus.result, 128'd323);
    step(1'b0, 64'h0, 64'h0);

    // Asynchronous reset between edges while the pipeline is full
    step(1'b1, 64'd3, 64'd5);
    step(1'b1, 64'd4, 64'd6);
    step(1'b1, 64'd8, 64'd8);
    check("prerst_ov", {127'h0, bus.out_valid}, 128'h1);
    #2 rst = 1'b1;
    #1;
    check("async_ov", {127'h0, bus.out_valid}, 128'h0);
    check("async_res", bus.result, 128'h0);
    model_clear();
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 64'h0, 64'h0);
      check("postrst_ov", {127'h0, bus.out_valid}, 128'h0);
    end
    run_one("postrst", 64'd7, 64'd6, 128'd42);

    // Random regression against the reference pipeline
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
    end
    for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
